// File: rtl/puf_challenge_scheduler.sv
// puf_challenge_scheduler
// Walks a sweep of PUF challenges. For each challenge it clears post_mux_counter,
// enables it until it reports finished, thresholds the captured count into one
// response bit and hands that bit to the serial TX path over valid/ready.
// Optional build macro: WATCHDOG_EN (aborts a RUN that exceeds TIMEOUT cycles and
// raises a sticky error flag; without it error is tied low).
module puf_challenge_scheduler #(
  parameter int unsigned NUM_CHALLENGES = 64,
  parameter int unsigned CHAL_W         = 7,
  parameter int unsigned CNT_W          = 7,
  parameter int unsigned TIMEOUT        = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  threshold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CHAL_W-1:0] challenge,
  output logic              cnt_reset,
  output logic              cnt_enable,
  input  logic [CNT_W-1:0]  cnt_value,
  input  logic              cnt_finished,
  output logic              resp_bit,
  output logic              resp_valid,
  input  logic              resp_ready
);

  // Reject impossible configurations at elaboration time.
  if (NUM_CHALLENGES < 1 || NUM_CHALLENGES > (2 ** CHAL_W) || TIMEOUT < 2) begin : g_bad_cfg
    $error("puf_challenge_scheduler: invalid NUM_CHALLENGES/CHAL_W/TIMEOUT");
  end

  localparam logic [CHAL_W-1:0] LAST_IDX = CHAL_W'(NUM_CHALLENGES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_EVAL,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t             state;
  logic [CHAL_W-1:0]  idx;
  logic [CNT_W-1:0]   captured;
  logic [CNT_W-1:0]   thr_reg;

  // The challenge index register drives the PUF mux directly, so challenge only
  // moves on an accepted start or a SEND handshake.
  assign challenge = idx;

`ifdef WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_cnt;
`else
  assign error = 1'b0;
`endif

  // Sweep sequencer: state, counter control pulses and response handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      captured   <= '0;
      thr_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt_reset  <= 1'b0;
      cnt_enable <= 1'b0;
      resp_bit   <= 1'b0;
      resp_valid <= 1'b0;
`ifdef WATCHDOG_EN
      wd_cnt     <= '0;
      error      <= 1'b0;
`endif
    end else begin
      // Single-cycle pulses default low.
      done      <= 1'b0;
      cnt_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            thr_reg   <= threshold;
            idx       <= '0;
            busy      <= 1'b1;
            cnt_reset <= 1'b1;
            state     <= ST_CLEAR;
`ifdef WATCHDOG_EN
            error     <= 1'b0;
`endif
          end
        end
        ST_CLEAR: begin
          cnt_enable <= 1'b1;
`ifdef WATCHDOG_EN
          wd_cnt     <= '0;
`endif
          state      <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt_finished) begin
            captured   <= cnt_value;
            cnt_enable <= 1'b0;
            state      <= ST_EVAL;
          end
`ifdef WATCHDOG_EN
          else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            cnt_enable <= 1'b0;
            error      <= 1'b1;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        ST_EVAL: begin
          resp_bit   <= (captured >= thr_reg);
          resp_valid <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx       <= idx + 1'b1;
              cnt_reset <= 1'b1;
              state     <= ST_CLEAR;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_scheduler.sv
// Testbench for puf_challenge_scheduler: behavioural post_mux_counter model,
// response scoreboard and protocol monitor.
module tb_puf_challenge_scheduler;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] threshold;
  logic       busy, done, error;
  logic [6:0] challenge;
  logic       cnt_reset, cnt_enable;
  logic [6:0] cnt_value;
  logic       cnt_finished;
  logic       resp_bit, resp_valid, resp_ready;

  typedef struct {
    int chal;
    int b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;

  int n_checks = 0;
  int n_errors = 0;
  int vals[NCH];
  int thr_exp;
  int run_cnt;
  bit never_finish;
  int done_count = 0;
  int hs_count = 0;
  bit valid_seen = 0;

  logic       prev_valid, prev_ready, prev_bit, prev_done, prev_en, prev_fin, prev_clr;
  logic [6:0] prev_chal;
  bit         saw_clear;

  puf_challenge_scheduler #(
    .NUM_CHALLENGES(NCH),
    .CHAL_W(7),
    .CNT_W(7),
    .TIMEOUT(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .threshold(threshold),
    .busy(busy),
    .done(done),
    .error(error),
    .challenge(challenge),
    .cnt_reset(cnt_reset),
    .cnt_enable(cnt_enable),
    .cnt_value(cnt_value),
    .cnt_finished(cnt_finished),
    .resp_bit(resp_bit),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counter model: finishes after 5 enabled cycles and reports the value for the
  // current challenge; the expected response is queued at that moment.
  always @(posedge clk) begin
    if (!reset || cnt_reset) begin
      run_cnt      <= 0;
      cnt_finished <= 1'b0;
      cnt_value    <= '0;
    end else if (cnt_enable && !cnt_finished && !never_finish) begin
      run_cnt <= run_cnt + 1;
      if (run_cnt == 4) begin
        cnt_finished <= 1'b1;
        cnt_value    <= 7'(vals[challenge[1:0]]);
        sb.push_back('{chal: int'(challenge), b: (vals[challenge[1:0]] >= thr_exp) ? 1 : 0});
      end
    end
  end

  // Monitor: scoreboard compare on handshake plus handshake/counter protocol rules.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
      prev_done  <= 1'b0;
      prev_en    <= 1'b0;
      prev_fin   <= 1'b0;
      prev_clr   <= 1'b0;
      saw_clear  <= 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", int'(resp_valid), 1);
        check("hold_bit", int'(resp_bit), int'(prev_bit));
        check("hold_chal", int'(challenge), int'(prev_chal));
      end
      if (prev_valid && prev_ready) check("valid_drop", int'(resp_valid), 0);
      if (resp_valid) valid_seen <= 1'b1;
      if (resp_valid && resp_ready) begin
        hs_count <= hs_count + 1;
        if (sb.size() == 0) check("resp_pending", sb.size(), 1);
        else begin
          mon_item = sb.pop_front();
          check("resp_chal", int'(challenge), mon_item.chal);
          check("resp_bit", int'(resp_bit), mon_item.b);
        end
      end
      if (done) begin
        done_count <= done_count + 1;
        check("done_busy", int'(busy), 1);
        check("done_sb_empty", sb.size(), 0);
      end
      if (prev_done) begin
        check("done_single", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
      end
      if (prev_clr) check("clr_single", int'(cnt_reset), 0);
      if (cnt_reset) check("clr_no_en", int'(cnt_enable), 0);
      if (!prev_en && cnt_enable) check("en_after_clr", int'(saw_clear), 1);
      if (prev_en && prev_fin) check("en_fall", int'(cnt_enable), 0);
      if (cnt_reset) saw_clear <= 1'b1;
      else if (!prev_en && cnt_enable) saw_clear <= 1'b0;
      prev_valid <= resp_valid;
      prev_ready <= resp_ready;
      prev_done  <= done;
      prev_en    <= cnt_enable;
      prev_fin   <= cnt_finished;
      prev_clr   <= cnt_reset;
    end
    prev_bit  <= resp_bit;
    prev_chal <= challenge;
  end

  task automatic check_idle(input string pfx);
    check({pfx, "_busy"}, int'(busy), 0);
    check({pfx, "_done"}, int'(done), 0);
    check({pfx, "_error"}, int'(error), 0);
    check({pfx, "_chal"}, int'(challenge), 0);
    check({pfx, "_cnt_reset"}, int'(cnt_reset), 0);
    check({pfx, "_cnt_enable"}, int'(cnt_enable), 0);
    check({pfx, "_resp_bit"}, int'(resp_bit), 0);
    check({pfx, "_resp_valid"}, int'(resp_valid), 0);
  endtask

  // Called at a negedge; start is seen by the DUT on the following posedge.
  task automatic start_sweep(input int thr);
    threshold = 7'(thr);
    thr_exp   = thr;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_chal", int'(challenge), 0);
    check("start_error", int'(error), 0);
    check("start_clr", int'(cnt_reset), 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done), 1);
    @(negedge clk);
    check("busy_low", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, dc, hc;
    logic       hb;
    logic [6:0] hch;
    reset        = 1'b0;
    start        = 1'b0;
    threshold    = '0;
    resp_ready   = 1'b1;
    never_finish = 1'b0;
    thr_exp      = 0;
    vals         = '{10, 50, 51, 127};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst");
    reset = 1'b1;
    @(negedge clk);

    // Basic sweep: bits 0,1,1,1 including the equality case.
    dc = done_count;
    start_sweep(50);
    wait_done(300);
    check("t1_done_count", done_count, dc + 1);
    check("t1_error", int'(error), 0);
    check("t1_sb_empty", sb.size(), 0);

    // Backpressure: hold ready low for 7 SEND cycles on challenge 0.
    vals = '{0, 127, 30, 31};
    resp_ready = 1'b0;
    hc = hs_count;
    start_sweep(31);
    k = 0;
    while (!resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t2_valid", int'(resp_valid), 1);
    hb  = resp_bit;
    hch = challenge;
    for (int i = 0; i < 7; i++) begin
      check("t2_stall_valid", int'(resp_valid), 1);
      check("t2_stall_bit", int'(resp_bit), int'(hb));
      check("t2_stall_chal", int'(challenge), int'(hch));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    wait_done(300);
    check("t2_handshakes", hs_count, hc + NCH);

    // start while busy is ignored; threshold 0 makes every bit 1.
    vals = '{0, 5, 20, 127};
    dc = done_count;
    start_sweep(0);
    k = 0;
    while (!(challenge == 7'd2 && cnt_enable) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t3_reach_chal2", int'(challenge), 2);
    threshold = 7'd99;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    threshold = '0;
    wait_done(300);
    check("t3_done_count", done_count, dc + 1);
    check("t3_sb_empty", sb.size(), 0);

    // Reset during SEND of challenge 1, then a fresh sweep from challenge 0.
    vals = '{10, 50, 51, 127};
    start_sweep(50);
    k = 0;
    while (!(challenge == 7'd1 && cnt_enable) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t4_reach_chal1", int'(challenge), 1);
    resp_ready = 1'b0;
    k = 0;
    while (!resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t4_valid", int'(resp_valid), 1);
    dc = done_count;
    reset = 1'b0;
    @(negedge clk);
    check_idle("t4");
    repeat (3) @(negedge clk);
    check("t4_no_done", done_count, dc);
    reset      = 1'b1;
    resp_ready = 1'b1;
    start_sweep(50);
    wait_done(300);
    check("t4_done_count", done_count, dc + 1);

`ifdef WATCHDOG_EN
    // Counter never finishes: abort after 20 RUN cycles with sticky error.
    begin
      int n_en;
      never_finish = 1'b1;
      valid_seen   = 1'b0;
      dc   = done_count;
      n_en = 0;
      start_sweep(10);
      k = 0;
      while (!done && k < 100) begin
        @(negedge clk);
        k++;
        if (cnt_enable) n_en++;
      end
      check("wd_run_cycles", n_en, 20);
      check("wd_done", int'(done), 1);
      check("wd_error", int'(error), 1);
      @(negedge clk);
      check("wd_busy_low", int'(busy), 0);
      check("wd_error_sticky", int'(error), 1);
      check("wd_no_valid", int'(valid_seen), 0);
      check("wd_done_count", done_count, dc + 1);
      never_finish = 1'b0;
      start_sweep(50);
      wait_done(300);
      check("wd_error_cleared", int'(error), 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/puf_challenge_scheduler.md
Name: puf_challenge_scheduler

Overview:
Sequencer that drives post_mux_counter across a sweep of PUF challenges.
- Per challenge: clears the counter, enables it until it reports finished, and thresholds the captured count into one response bit.
- Streams each response bit out over a valid/ready handshake toward the serial TX path.
- Sits between the host command decoder (start) and the UART transmitter (response stream).

Parameters:
NUM_CHALLENGES, 64, challenges per sweep; must be 1..2^CHAL_W.
CHAL_W, 7, challenge index width.
CNT_W, 7, counter value width; matches post_mux_counter out_counter.
TIMEOUT, 1000, max cycles in RUN before abort; used only with WATCHDOG_EN.

Ports:
clk  input  1  single system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
start  input  1  begin a sweep; sampled only in IDLE.
threshold  input  CNT_W  compare level; latched on accepted start.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at sweep end.
error  output  1  watchdog abort flag; see Optional Feature.
challenge  output  CHAL_W  current challenge index to the PUF mux.
cnt_reset  output  1  one-cycle clear pulse to counter reset (active high).
cnt_enable  output  1  counter enable.
cnt_value  input  CNT_W  counter out_counter.
cnt_finished  input  1  counter finished.
resp_bit  output  1  response bit for current challenge.
resp_valid  output  1  response bit available.
resp_ready  input  1  consumer accepts the bit.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE.
  - All outputs 0: busy, done, error, challenge, cnt_reset, cnt_enable, resp_bit, resp_valid.
  - Internal idx, captured count, threshold register and watchdog counter cleared.
  - Reset mid-sweep aborts immediately: no done pulse, in-flight bit dropped.
- States: IDLE, CLEAR, RUN, EVAL, SEND, DONE (registered one-hot or binary, implementer's choice).
- IDLE:
  - start==1: latch threshold, idx=0, challenge=0, -> CLEAR.
  - start is ignored in all other states; there is no queueing.
- CLEAR:
  - cnt_reset=1 for exactly this one cycle; cnt_enable=0. -> RUN.
- RUN:
  - cnt_enable=1.
  - When cnt_finished==1 is sampled: captured<=cnt_value (same edge), cnt_enable=0 from the next cycle, -> EVAL.
  - cnt_finished seen outside RUN is ignored.
- EVAL (one cycle):
  - resp_bit<=(captured >= threshold_reg), unsigned CNT_W compare.
  - resp_valid<=1. -> SEND.
- SEND:
  - resp_valid and resp_bit held stable until resp_valid&&resp_ready.
  - On handshake: resp_valid=0 next cycle.
  - If idx==NUM_CHALLENGES-1: -> DONE.
  - Else: idx+1, challenge=idx+1, -> CLEAR.
  - resp_ready while resp_valid==0 has no effect.
- DONE:
  - done=1 for one cycle; busy still 1. -> IDLE.
  - busy deasserts the cycle after done.
- challenge changes only on SEND handshake or on start; it is stable through CLEAR/RUN/EVAL.
- Timing: minimum per-challenge cycles = 1 (CLEAR) + R (RUN, R>=1) + 1 (EVAL) + 1 (SEND with ready high).
- Boundaries:
  - Equality captured==threshold gives resp_bit=1.
  - threshold=0: all bits 1.
  - NUM_CHALLENGES=1: single pass, then DONE.
  - idx never wraps.

Optional Feature:
Macro WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT-1 without cnt_finished: cnt_enable=0, no response emitted, error=1, -> DONE (done still pulses).
  - error is sticky until the next accepted start or reset.
- Not defined:
  - No watchdog logic; error tied 0; RUN waits indefinitely.

Test Plan:
- Basic sweep: NUM_CHALLENGES=4, threshold=50; counter model finishes after 5 cycles with values 10,50,51,127 -> resp_bits 0,1,1,1 on challenge 0..3; one done pulse; busy low afterwards.
- Backpressure: resp_ready low 7 cycles in SEND -> resp_valid/resp_bit held stable 7 cycles; challenge unchanged; exactly one bit per handshake.
- start while busy: pulse start during RUN of challenge 2 -> ignored; sweep continues to challenge 3 and a single done.
- Reset mid-operation: reset=0 during SEND of challenge 1 -> next cycle all outputs 0, state IDLE, no done; a subsequent start begins at challenge 0.
- Protocol check: every challenge shows exactly one cnt_reset pulse preceding cnt_enable rise; cnt_enable falls the cycle after cnt_finished.
- WATCHDOG_EN, TIMEOUT=20, counter never finishes -> after 20 RUN cycles cnt_enable=0, error=1, done pulse, no resp_valid; error clears on next start.
